// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule: takes the round-10 key and walks it back to the
// cipher key, emitting one round key per consumer handshake (round 10 down to 0).

module rom_sbox (
    input  logic [7:0] addr,
    output logic [7:0] data
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the most significant byte, so index from the top down.
    logic [10:0] idx;
    assign idx  = {~addr, 3'b000};
    assign data = SBOX[idx +: 8];
endmodule

module aes_inv_key_sched (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         v_i,
    input  logic [127:0] key_i,
    output logic         ready_o,
    output logic         v_o,
    output logic [127:0] data_o,
    output logic [3:0]   round_o,
    output logic         last_o,
    input  logic         yumi_i
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state;
    logic [127:0] key_q;
    logic [3:0]   round_q;
    logic         ready_q;
    logic         v_q;
    logic         last_q;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  n0, n1, n2, n3;
    logic [31:0]  rot_word, sub_word;
    logic [127:0] prev_key;

    assign {w0, w1, w2, w3} = key_q;

    // Undo the forward expansion: the last three words fall out of neighbouring
    // XORs, and the first word needs the recovered previous-round w3 through g().
    assign n3       = w3 ^ w2;
    assign n2       = w2 ^ w1;
    assign n1       = w1 ^ w0;
    assign rot_word = {n3[23:0], n3[31:24]};

    rom_sbox u_sbox0 (.addr(rot_word[31:24]), .data(sub_word[31:24]));
    rom_sbox u_sbox1 (.addr(rot_word[23:16]), .data(sub_word[23:16]));
    rom_sbox u_sbox2 (.addr(rot_word[15:8]),  .data(sub_word[15:8]));
    rom_sbox u_sbox3 (.addr(rot_word[7:0]),   .data(sub_word[7:0]));

    assign n0       = w0 ^ sub_word ^ {rcon(round_q), 24'h0};
    assign prev_key = {n0, n1, n2, n3};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            ready_q <= 1'b1;
            v_q     <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (v_i) begin
                        state   <= EMIT;
                        key_q   <= key_i;
                        round_q <= 4'd10;
                        ready_q <= 1'b0;
                        v_q     <= 1'b1;
                        last_q  <= 1'b0;
                    end
                end
                EMIT: begin
                    if (yumi_i) begin
                        if (round_q != 4'd0) begin
                            key_q   <= prev_key;
                            round_q <= round_q - 4'd1;
                            last_q  <= (round_q == 4'd1);
                        end else begin
                            state   <= IDLE;
                            ready_q <= 1'b1;
                            v_q     <= 1'b0;
                            last_q  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready_o = ready_q;
    assign v_o     = v_q;
    assign data_o  = key_q;
    assign round_o = round_q;
    assign last_o  = last_q;
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: known-answer table plus random keys checked
// against a forward AES-128 key expansion built from GF(2^8) arithmetic.

module tb_aes_inv_key_sched;
    logic         clk = 1'b0;
    logic         reset;
    logic         v_i;
    logic [127:0] key_i;
    logic         ready_o;
    logic         v_o;
    logic [127:0] data_o;
    logic [3:0]   round_o;
    logic         last_o;
    logic         yumi_i;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] rk [0:10];

    aes_inv_key_sched dut (
        .clk_i   (clk),
        .reset_i (reset),
        .v_i     (v_i),
        .key_i   (key_i),
        .ready_o (ready_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .round_o (round_o),
        .last_o  (last_o),
        .yumi_i  (yumi_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   round;
        logic [127:0] data;
        logic         last;
    } vec_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse (a^254) then the affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        if (a == 8'h00) inv = 8'h00;
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] t);
        logic [31:0] r = {t[23:0], t[31:24]};
        return {sbox_m[r[31:24]], sbox_m[r[23:16]], sbox_m[r[15:8]], sbox_m[r[7:0]]};
    endfunction

    task automatic expand(input logic [127:0] k0);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        {w[0], w[1], w[2], w[3]} = k0;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_rot(t) ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check_output(input string nm, input logic [127:0] act, input logic [127:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!ready_o && n < 30) begin
            step();
            n++;
        end
        check_output("ready_wait", 128'(ready_o), 128'd1);
    endtask

    // Full sequence for rk[], optionally with random stalls and stray v_i pulses during EMIT.
    task automatic apply_stimulus(input bit rand_yumi, input bit poke_vi);
        int r = 10;
        int stall = 0;
        logic y;
        wait_ready();
        v_i = 1'b1;
        key_i = rk[10];
        step();
        v_i = 1'b0;
        while (r >= 0) begin
            check_output("v_o", 128'(v_o), 128'd1);
            check_output("ready_o_emit", 128'(ready_o), 128'd0);
            check_output("round_o", 128'(round_o), 128'(r));
            check_output("data_o", data_o, rk[r]);
            check_output("last_o", 128'(last_o), 128'(r == 0));
            y = rand_yumi ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall >= 6) y = 1'b1;
            yumi_i = y;
            if (poke_vi) begin
                v_i   = 1'($urandom_range(0, 1));
                key_i = rand_key();
            end
            step();
            if (y) begin
                r--;
                stall = 0;
            end else begin
                stall++;
            end
        end
        yumi_i = 1'b0;
        v_i    = 1'b0;
        check_output("done_v_o", 128'(v_o), 128'd0);
        check_output("done_ready_o", 128'(ready_o), 128'd1);
    endtask

    task automatic check_reset_state(input string nm);
        check_output({nm, "_v_o"}, 128'(v_o), 128'd0);
        check_output({nm, "_ready_o"}, 128'(ready_o), 128'd1);
        check_output({nm, "_last_o"}, 128'(last_o), 128'd0);
        check_output({nm, "_data_o"}, data_o, 128'd0);
        check_output({nm, "_round_o"}, 128'(round_o), 128'd0);
    endtask

    initial begin
        vec_t         vecs [4];
        logic [127:0] obs_data [0:10];
        logic         obs_last [0:10];
        logic [127:0] key_b;

        vecs[0] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0};
        vecs[1] = '{4'd9,  128'hac7766f319fadc2128d12941575c006e, 1'b0};
        vecs[2] = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b0};
        vecs[3] = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1};

        for (int i = 0; i < 256; i++) sbox_m[i] = sbox_calc(8'(i));

        reset  = 1'b1;
        v_i    = 1'b0;
        yumi_i = 1'b0;
        key_i  = '0;
        step();
        step();
        reset = 1'b0;
        check_reset_state("reset");

        // Known-answer run with yumi held high.
        v_i   = 1'b1;
        key_i = vecs[0].data;
        step();
        v_i    = 1'b0;
        yumi_i = 1'b1;
        for (int r = 10; r >= 0; r--) begin
            check_output("kat_round", 128'(round_o), 128'(r));
            obs_data[r] = data_o;
            obs_last[r] = last_o;
            step();
        end
        yumi_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("kat_data_r%0d", vecs[i].round), obs_data[vecs[i].round], vecs[i].data);
            check_output($sformatf("kat_last_r%0d", vecs[i].round), 128'(obs_last[vecs[i].round]), 128'(vecs[i].last));
        end

        // Known key with random stalls, then with stray v_i pulses.
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1);

        // Reset at round 5, asserted together with v_i and yumi_i.
        expand(rand_key());
        wait_ready();
        v_i   = 1'b1;
        key_i = rk[10];
        step();
        v_i    = 1'b0;
        yumi_i = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check_output("pre_reset_round", 128'(round_o), 128'd5);
        reset = 1'b1;
        v_i   = 1'b1;
        key_i = rand_key();
        step();
        reset  = 1'b0;
        v_i    = 1'b0;
        yumi_i = 1'b0;
        check_reset_state("midreset");
        step();
        check_output("midreset_hold_v_o", 128'(v_o), 128'd0);
        expand(rand_key());
        apply_stimulus(1'b0, 1'b0);

        // Back-to-back keys with v_i held high.
        expand(rand_key());
        key_b = rand_key();
        wait_ready();
        v_i   = 1'b1;
        key_i = rk[10];
        step();
        key_i  = key_b;
        yumi_i = 1'b1;
        for (int r = 10; r >= 0; r--) begin
            check_output("b2b_data", data_o, rk[r]);
            step();
        end
        yumi_i = 1'b0;
        check_output("b2b_ready", 128'(ready_o), 128'd1);
        check_output("b2b_gap_v_o", 128'(v_o), 128'd0);
        step();
        v_i = 1'b0;
        check_output("b2b_second_v_o", 128'(v_o), 128'd1);
        check_output("b2b_second_round", 128'(round_o), 128'd10);
        check_output("b2b_second_data", data_o, key_b);
        yumi_i = 1'b1;
        for (int i = 0; i < 11; i++) step();
        yumi_i = 1'b0;
        check_output("b2b_second_done", 128'(ready_o), 128'd1);

        // Random keys against the forward expansion model.
        for (int i = 0; i < 1000; i++) begin
            expand(rand_key());
            apply_stimulus(i % 2 == 1, i % 4 == 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/aes_inv_key_sched.md
AES_INV_KEY_SCHED -- requirements
Module: aes_inv_key_sched

Interface
REQ-001 SHALL have no parameters; AES-128 only, 10 rounds fixed.
REQ-002 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-003 reset_i  input  1  synchronous, active-high reset.
REQ-004 v_i  input  1  key_i valid.
REQ-005 key_i  input  128  round-10 (final) round key; word w0 = key_i[127:96], w3 = key_i[31:0].
REQ-006 ready_o  output  1  block can accept key_i.
REQ-007 v_o  output  1  data_o/round_o valid.
REQ-008 data_o  output  128  current round key, same word ordering as key_i.
REQ-009 round_o  output  4  round index of data_o, 10 down to 0.
REQ-010 last_o  output  1  high when round_o == 0 and v_o == 1.
REQ-011 yumi_i  input  1  consumer takes data_o this cycle; legal only when v_o == 1.

Function
REQ-012 SHALL use a two-state FSM: IDLE, EMIT.
REQ-013 IDLE: ready_o = 1, v_o = 0; v_i & ready_o loads key_i into the key register, sets round counter to 10, and moves to EMIT next cycle.
REQ-014 EMIT: ready_o = 0, v_o = 1, data_o = key register, round_o = round counter; v_i is ignored.
REQ-015 EMIT with yumi_i and round counter > 0: the key register SHALL take the inverse step for round r = counter, the counter SHALL decrement, and the FSM SHALL stay in EMIT.
REQ-016 Inverse step, all XOR on 32-bit words: n3 = w3^w2; n2 = w2^w1; n1 = w1^w0; n0 = w0 ^ SubWord(RotWord(n3)) ^ {Rcon[r],24'h0}.
REQ-017 RotWord({a,b,c,d}) = {b,c,d,a}; SubWord applies the AES forward S-box per byte using four rom_sbox instances.
REQ-018 Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 (hex); Rcon may come from rom_rc or a local case; index 0 is never used.
REQ-019 EMIT with yumi_i and counter == 0: FSM SHALL return to IDLE next cycle; v_o = 0 and ready_o = 1 that cycle; no same-cycle reload (no ready_o/yumi_i combinational path).
REQ-020 EMIT without yumi_i: data_o, round_o and last_o SHALL hold stable for any number of cycles.
REQ-021 Latency: first key (round 10) valid 1 cycle after acceptance; each next key valid 1 cycle after yumi_i; full sequence is 11 outputs, minimum 12 cycles from accept to next ready_o.
REQ-022 ready_o and v_o SHALL be purely state-decoded registered values, never both high.
REQ-023 The datapath step SHALL be combinational within one cycle, with no pipelining of the S-box path.

Reset
REQ-024 reset_i high at any edge SHALL force IDLE, counter = 0, and key register = 0; on the next cycle v_o = 0, ready_o = 1, last_o = 0, data_o = 0, round_o = 0.
REQ-025 Reset mid-sequence SHALL abandon the sequence without emitting further keys.
REQ-026 reset_i SHALL take priority over v_i and yumi_i in the same cycle.

Verification
REQ-027 key_i = d014f9a8c9ee2589e13f0cc8b6630ca6, yumi_i held high -> round_o 10..0 on consecutive cycles:
- round 10: data_o = d014f9a8c9ee2589e13f0cc8b6630ca6
- round 9: data_o = ac7766f319fadc2128d12941575c006e
- round 1: data_o = a0fafe1788542cb123a339392a6c7605
- round 0: data_o = 2b7e151628aed2a6abf7158809cf4f3c, last_o = 1
REQ-028 Same key, yumi_i toggled randomly -> same 11-value sequence; outputs stable while yumi_i = 0; no value skipped or duplicated.
REQ-029 v_i pulsed with a different key during EMIT -> ignored; sequence continues unchanged; ready_o = 0 throughout.
REQ-030 reset_i asserted at round_o = 5 -> next cycle v_o = 0, ready_o = 1; a new key accepted afterward yields a correct full sequence starting at round 10.
REQ-031 Back-to-back keys with v_i held high -> ready_o rises exactly 1 cycle after the round-0 yumi_i; the second key is accepted that cycle and its round 10 key appears 1 cycle later.
REQ-032 Random keys, compared against a forward AES-128 key-expansion model -> all 11 round keys match, for at least 1000 keys.
